// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package ifetch_pkg;

  // Default memory address width (bytes) and prefetch depth.
  localparam int ADDR_W_DEF = 7;
  localparam int DEPTH_DEF  = 4;

  // Issue state: IDLE issues nothing, Bk issues byte k of the current word.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    B3   = 3'd4
  } fetch_state_e;

  // One prefetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fifo_entry_t;

  // Byte offset within the word that a given issue state requests.
  function automatic logic [1:0] byte_offset(input fetch_state_e st);
    logic [1:0] off;
    off = 2'd0;
    case (st)
      B1:      off = 2'd1;
      B2:      off = 2'd2;
      B3:      off = 2'd3;
      default: off = 2'd0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries with a registered head output.
// The head register always shows the entry that is at the front after the
// current cycle's push/pop, and is all-zero whenever the FIFO is empty.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fifo_entry_t            push_data_i,
  input  logic                   pop_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   head_valid_o,
  output fifo_entry_t            head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fifo_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   after_pop;
  fifo_entry_t        head_q, head_d;
  logic               head_valid_q, head_valid_d;
  logic               do_push, do_pop, full;

  // Next-state for pointers, occupancy and the registered head; flush wins.
  always_comb begin
    full         = (count_q == CNT_W'(DEPTH));
    do_pop       = pop_i && (count_q != '0);
    do_push      = push_i && (!full || do_pop);
    after_pop    = count_q - CNT_W'(do_pop);
    rd_ptr_d     = rd_ptr_q + PTR_W'(do_pop);
    wr_ptr_d     = wr_ptr_q + PTR_W'(do_push);
    count_d      = after_pop + CNT_W'(do_push);
    head_d       = '0;
    head_valid_d = 1'b0;
    if (after_pop != '0) begin
      // Older entry remains at the front; it was written in an earlier cycle.
      head_d       = mem_q[rd_ptr_d];
      head_valid_d = 1'b1;
    end else if (do_push) begin
      // FIFO drains to empty this cycle, so the incoming entry becomes head.
      head_d       = push_data_i;
      head_valid_d = 1'b1;
    end
    if (flush_i) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      head_d       = '0;
      head_valid_d = 1'b0;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  // Entry storage; contents past the pointers are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !reset) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = head_valid_q;
  assign head_o       = head_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: reads a byte-wide memory one byte per cycle,
// assembles big-endian 32-bit words and buffers them with their PC.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  input  logic              inst_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [31:0]       fpc_q, fpc_d;
  // Bytes 0..2 of the word under assembly; byte 3 is taken straight from memory.
  logic [23:0]       asm_q, asm_d;
  // Tag of the byte returning this cycle. Clearing the valid bit is how a
  // redirect drops the byte that is still in flight.
  logic              rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_off_q, rsp_off_d;
  logic [31:0]       rsp_pc_q, rsp_pc_d;

  logic              issue;
  logic              pop;
  logic              push;
  logic              pending;
  logic              slot_free;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W-1:0]  fifo_count;
  logic              head_valid;
  fifo_entry_t       head;
  fifo_entry_t       push_entry;

  // Memory request, handshake and slot-availability decode.
  always_comb begin
    issue      = (state_q != IDLE) && !reset;
    mem_rd     = issue;
    mem_addr   = reset ? '0 : fpc_q[ADDR_W-1:0] + ADDR_W'(byte_offset(state_q));
    pop        = head_valid && inst_ready;
    push       = rsp_valid_q && (rsp_off_q == 2'd3);
    // The word in B3 is still owed a slot; in IDLE only a word landing now is.
    pending    = (state_q == B3) || push;
    occupancy  = {1'b0, fifo_count} - (CNT_W + 1)'(pop) + (CNT_W + 1)'(pending);
    slot_free  = occupancy < (CNT_W + 1)'(DEPTH);
    push_entry.pc   = rsp_pc_q;
    push_entry.inst = {asm_q, mem_data};
  end

  // Issue sequencing and fetch PC; redirect overrides every other transition.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    case (state_q)
      B0:      state_d = B1;
      B1:      state_d = B2;
      B2:      state_d = B3;
      default: begin
        if (slot_free) begin
          state_d = B0;
          fpc_d   = fpc_q + 32'd4;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    if (redirect) begin
      state_d = B0;
      fpc_d   = redirect_pc & 32'hFFFF_FFFC;
    end
  end

  // Byte assembly and bookkeeping for the byte that returns next cycle.
  always_comb begin
    asm_d = asm_q;
    if (rsp_valid_q) begin
      case (rsp_off_q)
        2'd0:    asm_d[23:16] = mem_data;
        2'd1:    asm_d[15:8]  = mem_data;
        2'd2:    asm_d[7:0]   = mem_data;
        default: asm_d        = asm_q;
      endcase
    end
    rsp_valid_d = issue && !redirect;
    rsp_off_d   = byte_offset(state_q);
    rsp_pc_d    = fpc_q;
  end

  // State registers; reset lands in the same state as a redirect to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= B0;
      fpc_q       <= '0;
      asm_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_off_q   <= '0;
      rsp_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      asm_q       <= asm_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_off_q   <= rsp_off_d;
      rsp_pc_q    <= rsp_pc_d;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (redirect),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .count_o      (fifo_count),
    .head_valid_o (head_valid),
    .head_o       (head)
  );

  assign inst_valid = head_valid;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a word-level reference model.
module tb_ifetch_unit;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              inst_ready;

  ifetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int saw4     = 0;
  bit watch4   = 0;

  logic [7:0] mem [128];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  // Model state: queue of buffered words, word being issued, word awaiting push.
  ent_t        mq[$];
  bit          m_ok = 0;
  bit          m_issuing = 0;
  int          m_k = 0;
  logic [31:0] m_pc = '0;
  bit          m_pend = 0;
  logic [31:0] m_pend_pc = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [6:0] a;
    a = pc[6:0];
    return {mem[a], mem[7'(a + 7'd1)], mem[7'(a + 7'd2)], mem[7'(a + 7'd3)]};
  endfunction

  // Byte-wide memory with one cycle of read latency.
  always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : 8'($urandom);

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  // Reference model, advanced once per clock from the inputs of the ending cycle.
  always @(posedge clk) begin
    if (reset) begin
      m_ok = 1; mq.delete(); m_pend = 0; m_issuing = 1; m_k = 0; m_pc = '0;
    end else if (m_ok) begin
      bit          m_pop;
      bit          push_now;
      logic [31:0] push_pc;
      int          owed;
      ent_t        e;
      if (redirect) begin
        mq.delete(); m_pend = 0; m_issuing = 1; m_k = 0;
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        m_pop     = (mq.size() > 0) && inst_ready;
        push_now  = m_pend;
        push_pc   = m_pend_pc;
        m_pend    = m_issuing && (m_k == 3);
        m_pend_pc = m_pc;
        if (m_issuing && m_k < 3) begin
          m_k++;
        end else begin
          owed = m_issuing ? 1 : int'(push_now);
          if (mq.size() - int'(m_pop) + owed < DEPTH) begin
            m_issuing = 1; m_k = 0; m_pc = m_pc + 32'd4;
          end else begin
            m_issuing = 0;
          end
        end
        if (m_pop) void'(mq.pop_front());
        if (push_now) begin
          e.pc = push_pc;
          e.w  = word_at(push_pc);
          mq.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      logic exp_rd;
      exp_rd = m_issuing && !reset;
      chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
      if (reset) chk("mem_addr_rst", 32'(mem_addr), 32'h0);
      else if (exp_rd) chk("mem_addr", 32'(mem_addr), (m_pc + 32'(m_k)) & 32'h7F);
      chk("inst_valid", 32'(inst_valid), 32'(mq.size() > 0));
      chk("inst", inst, (mq.size() > 0) ? mq[0].w : 32'h0);
      chk("inst_pc", inst_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
    end
    if (watch4 && inst_valid && inst_pc == 32'h4) saw4++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go_to(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 200) begin
      tick();
      guard++;
    end
    if (cyc != n) chk("cycle_timeout", 32'(cyc), 32'(n));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 29 + 7);
    mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;
    mem[4] = 8'h8C; mem[5] = 8'h09; mem[6] = 8'h00; mem[7] = 8'h04;
    mem[8'h40] = 8'h12; mem[8'h41] = 8'h34; mem[8'h42] = 8'h56; mem[8'h43] = 8'h78;
    mem[8'h7C] = 8'hDE; mem[8'h7D] = 8'hAD; mem[8'h7E] = 8'hBE; mem[8'h7F] = 8'hEF;

    // Basic streaming with the core always ready.
    inst_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("t1_c0_rd", 32'(mem_rd), 32'h1);
    chk("t1_c0_addr", 32'(mem_addr), 32'h0);
    go_to(4); @(negedge clk);
    chk("t1_c4_valid", 32'(inst_valid), 32'h0);
    go_to(5); @(negedge clk);
    chk("t1_c5_inst", inst, 32'h20080005);
    chk("t1_c5_pc", inst_pc, 32'h0);
    go_to(9); @(negedge clk);
    chk("t1_c9_inst", inst, 32'h8C090004);
    chk("t1_c9_pc", inst_pc, 32'h4);

    // Back-pressure: fill the FIFO, then release exactly one word.
    inst_ready = 1'b0;
    do_reset();
    go_to(15); @(negedge clk);
    chk("t2_c15_addr", 32'(mem_addr), 32'h0F);
    go_to(16); @(negedge clk);
    chk("t2_c16_rd", 32'(mem_rd), 32'h0);
    go_to(20);
    inst_ready = 1'b1;
    @(negedge clk);
    chk("t2_c20_rd", 32'(mem_rd), 32'h0);
    chk("t2_c20_pc", inst_pc, 32'h0);
    tick();
    inst_ready = 1'b0;
    @(negedge clk);
    chk("t2_c21_rd", 32'(mem_rd), 32'h1);
    chk("t2_c21_addr", 32'(mem_addr), 32'h10);
    chk("t2_c21_pc", inst_pc, 32'h4);
    go_to(30); @(negedge clk);
    chk("t2_c30_rd", 32'(mem_rd), 32'h0);
    chk("t2_c30_pc", inst_pc, 32'h4);

    // Redirect while the word at 4 is half assembled.
    inst_ready = 1'b1;
    do_reset();
    go_to(6);
    redirect = 1'b1; redirect_pc = 32'h40; watch4 = 1;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("t3_c7_valid", 32'(inst_valid), 32'h0);
    chk("t3_c7_addr", 32'(mem_addr), 32'h40);
    go_to(11); @(negedge clk);
    chk("t3_c11_valid", 32'(inst_valid), 32'h0);
    go_to(12); @(negedge clk);
    chk("t3_c12_pc", inst_pc, 32'h40);
    chk("t3_c12_inst", inst, 32'h12345678);
    go_to(24); @(negedge clk);
    watch4 = 0;
    chk("t3_no_pc4", 32'(saw4), 32'h0);

    // Misaligned redirect target is truncated.
    do_reset();
    go_to(3);
    redirect = 1'b1; redirect_pc = 32'h43;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("t4_c4_addr", 32'(mem_addr), 32'h40);
    go_to(9); @(negedge clk);
    chk("t4_c9_pc", inst_pc, 32'h40);
    chk("t4_c9_inst", inst, 32'h12345678);

    // Address wrap at the end of memory; PC keeps counting.
    do_reset();
    go_to(2);
    redirect = 1'b1; redirect_pc = 32'h7C;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("t5_c3_addr", 32'(mem_addr), 32'h7C);
    go_to(7); @(negedge clk);
    chk("t5_c7_addr", 32'(mem_addr), 32'h00);
    go_to(8); @(negedge clk);
    chk("t5_c8_pc", inst_pc, 32'h7C);
    chk("t5_c8_inst", inst, 32'hDEADBEEF);
    go_to(10); @(negedge clk);
    chk("t5_c10_addr", 32'(mem_addr), 32'h03);
    go_to(12); @(negedge clk);
    chk("t5_c12_pc", inst_pc, 32'h80);
    chk("t5_c12_inst", inst, 32'h20080005);

    // Reset in B2 with two words buffered.
    inst_ready = 1'b0;
    do_reset();
    go_to(9); @(negedge clk);
    chk("t6_c9_valid", 32'(inst_valid), 32'h1);
    chk("t6_c9_pc", inst_pc, 32'h0);
    go_to(10);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_rd", 32'(mem_rd), 32'h0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_r0_valid", 32'(inst_valid), 32'h0);
    chk("t6_r0_addr", 32'(mem_addr), 32'h0);
    go_to(4); @(negedge clk);
    chk("t6_r4_valid", 32'(inst_valid), 32'h0);
    go_to(5); @(negedge clk);
    chk("t6_r5_inst", inst, 32'h20080005);
    chk("t6_r5_pc", inst_pc, 32'h0);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
